// File: rtl/uart_io.sv
// 8N1 UART transceiver behind the IO decoder: transmits the low byte of a store on
// start_i, receives bytes into a holding register flagged by ready_o until clear_i.
`timescale 1ns/1ps
module uart_io #(
    parameter int WORD         = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [WORD-1:0] tx_data_i,
    input  logic            clear_i,
    input  logic            rxd_i,
    output logic            txd_o,
    output logic            busy_o,
    output logic            ready_o,
    output logic [WORD-1:0] rx_data_o,
    output logic            frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // ---------------- transmitter ----------------
    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_sh_q, tx_sh_d;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            tx_tick;

    assign tx_tick = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_IDLE:  if (start_i) tx_state_d = S_START;
            S_START: if (tx_tick) tx_state_d = S_DATA;
            S_DATA:  if (tx_tick && tx_idx_q == 3'd7) tx_state_d = S_STOP;
            S_STOP:  if (tx_tick) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    // txd_d is the value for the next bit period, so txd_o stays registered
    always_comb begin
        tx_cnt_d = (tx_state_q == S_IDLE || tx_tick) ? '0 : tx_cnt_q + CNT_ONE;
        tx_idx_d = tx_idx_q;
        tx_sh_d  = tx_sh_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        case (tx_state_q)
            S_IDLE: begin
                if (start_i) begin
                    tx_sh_d  = tx_data_i[7:0];
                    tx_idx_d = 3'd0;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: if (tx_tick) txd_d = tx_sh_q[0];
            S_DATA: begin
                if (tx_tick) begin
                    if (tx_idx_q == 3'd7) begin
                        txd_d = 1'b1;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        txd_d    = tx_sh_q[1];
                    end
                end
            end
            S_STOP: if (tx_tick) busy_d = 1'b0;
            default: ;
        endcase
    end

    assign txd_o  = txd_q;
    assign busy_o = busy_q;

    // ---------------- receiver ----------------
    logic [1:0]      sync_q;
    logic            rx_s;
    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [WORD-1:0] rx_data_q, rx_data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            rx_bit_tick, rx_half_tick;

    assign rx_s         = sync_q[1];
    assign rx_bit_tick  = (rx_cnt_q == BIT_LAST);
    assign rx_half_tick = (rx_cnt_q == HALF_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rxd_i};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (!rx_s) rx_state_d = S_START;
            S_START: if (rx_half_tick) rx_state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_bit_tick && rx_idx_q == 3'd7) rx_state_d = S_STOP;
            S_STOP:  if (rx_bit_tick) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // a good stop sample takes priority over a coincident clear
    always_comb begin
        rx_cnt_d  = rx_cnt_q + CNT_ONE;
        rx_idx_d  = rx_idx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        ready_d   = clear_i ? 1'b0 : ready_q;
        ferr_d    = ferr_q;
        case (rx_state_q)
            S_IDLE: rx_cnt_d = '0;
            S_START: begin
                if (rx_half_tick) begin
                    rx_cnt_d = '0;
                    rx_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (rx_bit_tick) begin
                    rx_cnt_d = '0;
                    rx_idx_d = rx_idx_q + 3'd1;
                    rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                end
            end
            S_STOP: begin
                if (rx_bit_tick) begin
                    rx_cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d = WORD'(rx_sh_q);
                        ready_d   = 1'b1;
                        ferr_d    = 1'b0;
                    end else begin
                        ferr_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign ready_o     = ready_q;
    assign rx_data_o   = rx_data_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io at 4 clocks per bit: reset/idle, transmit framing,
// receive, frame error, glitch rejection, clear race and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_io;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst, start, clear, rxd;
    logic [31:0] tx_data;
    logic        txd, busy, ready, frame_err;
    logic [31:0] rx_data;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    uart_io #(.WORD(32), .CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx_data),
        .clear_i(clear), .rxd_i(rxd), .txd_o(txd), .busy_o(busy),
        .ready_o(ready), .rx_data_o(rx_data), .frame_err_o(frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and checks txd/busy each cycle; optionally pokes start mid-frame.
    task automatic tx_frame(input logic [31:0] d, input bit poke);
        logic [9:0] frm;
        frm     = {1'b1, d[7:0], 1'b0};
        start   = 1'b1;
        tx_data = d;
        tick();
        for (int k = 0; k < 10 * CPB; k++) begin
            chk("txd_bit", {31'b0, txd}, {31'b0, frm[k / CPB]});
            chk("busy_hi", {31'b0, busy}, 32'd1);
            if (poke && k == 19) begin
                start   = 1'b1;
                tx_data = ~d;
            end else begin
                start   = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("txd_end", {31'b0, txd}, 32'd1);
    endtask

    // Drives one serial frame on rxd; clr asserts clear on the stop-sample cycle.
    task automatic send_rx(input logic [7:0] b, input bit stop, input bit clr);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            rxd = f[i / CPB];
            tick();
        end
        rxd   = 1'b1;
        clear = clr;
        tick();
        clear = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; rxd = 1'b1; tx_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            chk("idle_txd", {31'b0, txd}, 32'd1);
            chk("idle_busy", {31'b0, busy}, 32'd0);
            chk("idle_ready", {31'b0, ready}, 32'd0);
            chk("idle_rxdata", rx_data, 32'd0);
            chk("idle_ferr", {31'b0, frame_err}, 32'd0);
            tick();
        end

        // transmit with an ignored start mid-frame, then back-to-back start
        tx_frame(32'hDEADBEA5, 1'b1);
        tx_frame(32'h00000033, 1'b0);

        // good receive, then clear
        send_rx(8'h3C, 1'b1, 1'b0);
        chk("rx3c_ready", {31'b0, ready}, 32'd1);
        chk("rx3c_data", rx_data, 32'h0000003C);
        chk("rx3c_ferr", {31'b0, frame_err}, 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_ready", {31'b0, ready}, 32'd0);
        chk("clr_data", rx_data, 32'h0000003C);

        // framing error, then recovery
        send_rx(8'h55, 1'b0, 1'b0);
        chk("fe_ferr", {31'b0, frame_err}, 32'd1);
        chk("fe_ready", {31'b0, ready}, 32'd0);
        chk("fe_data", rx_data, 32'h0000003C);
        send_rx(8'h12, 1'b1, 1'b0);
        chk("rx12_ferr", {31'b0, frame_err}, 32'd0);
        chk("rx12_ready", {31'b0, ready}, 32'd1);
        chk("rx12_data", rx_data, 32'h00000012);
        clear = 1'b1; tick(); clear = 1'b0;

        // 2-cycle glitch must not start a frame
        rxd = 1'b0; tick(); tick(); rxd = 1'b1;
        repeat (50) tick();
        chk("gl_ready", {31'b0, ready}, 32'd0);
        chk("gl_data", rx_data, 32'h00000012);
        chk("gl_ferr", {31'b0, frame_err}, 32'd0);

        // overrun with ready set, then clear racing a good stop sample
        send_rx(8'h34, 1'b1, 1'b0);
        chk("rx34_data", rx_data, 32'h00000034);
        send_rx(8'h81, 1'b1, 1'b1);
        chk("race_ready", {31'b0, ready}, 32'd1);
        chk("race_data", rx_data, 32'h00000081);

        // reset during data bit 4 of a transmit
        start = 1'b1; tx_data = 32'h0; tick(); start = 1'b0;
        repeat (21) tick();
        chk("bit4_txd", {31'b0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_data", rx_data, 32'd0);
        tick(); rst = 1'b0; tick();
        tx_frame(32'h00000000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_io.md
# uart_io

Byte-wide UART transceiver that sits directly behind the memory-mapped IO decoder. It transmits the low byte of a store when pulsed with `start`. It receives serial bytes into a holding register, flagged by `ready` until `clear`. It supplies the `r_data`, `ready` and `busy` inputs the decoder muxes onto the load path as data and state words. Format is fixed at 8N1, LSB first.

## Interface
- `WORD`, 32, data bus width; matches the core's word size.
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); legal range ≥ 4.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle transmit request from the IO decoder.
- `tx_data`  in  WORD  store data; only bits [7:0] are transmitted.
- `clear`  in  1  one-cycle acknowledge of received byte; drops `ready`.
- `rxd`  in  1  serial input, asynchronous to `clk`.
- `txd`  out  1  serial output, idles high.
- `busy`  out  1  transmitter occupied.
- `ready`  out  1  unread received byte in `rx_data`.
- `rx_data`  out  WORD  last good received byte, zero-extended.
- `frame_err`  out  1  last frame had a low stop bit; sticky until the next good frame.

## Operation
- Reset values: `txd`=1, `busy`=0, `ready`=0, `rx_data`=0, `frame_err`=0. Both FSMs go to IDLE and counters go to 0. Reset mid-frame aborts the frame, and `txd` returns high asynchronously.
- Bit timer: counter of width $clog2(CLKS_PER_BIT); one bit period = CLKS_PER_BIT cycles.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `start`=1 latches `tx_data[7:0]` into the shift register, sets `busy`, and enters START.
  - START: `txd`=0 for one bit period.
  - DATA: 8 bits LSB first, one bit period each; a 3-bit index counts 0..7.
  - STOP: `txd`=1 for one bit period, then IDLE with `busy`=0.
  - `start` while `busy`=1 is ignored; the in-flight byte and latched data are unchanged.
- RX input: `rxd` passes through a 2-flop synchronizer whose flops reset to 1. All RX logic uses the synchronized value.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a low synchronized input enters START, with the timer cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If high, it is a glitch: return to IDLE with no flag change. If low, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles at bit centres, shifting in LSB first, 8 samples.
  - STOP: sample one bit period later.
    - Sample 1: `rx_data`←{24'b0, byte}, `ready`←1, `frame_err`←0.
    - Sample 0: `frame_err`←1; `rx_data` and `ready` are unchanged and the byte is discarded.
  - Either way the FSM returns to IDLE immediately; the next falling edge is accepted from the following cycle.
- Overrun: a good byte arriving while `ready`=1 overwrites `rx_data`, and `ready` stays 1.
- `clear`: `ready`←0 on the next edge. If `clear` and a good stop sample occur in the same cycle, the new byte wins: `ready`=1 and `rx_data` holds the new byte.
- TX and RX are fully independent, and simultaneous operation is legal.

## Timing
- `busy` rises on the edge that samples `start`=1. `txd` falls on that same edge.
- `busy` stays high for exactly 10×CLKS_PER_BIT cycles. `start` is accepted again in the first cycle after `busy` falls.
- RX latency from an `rxd` falling edge to `ready` rising is 2 (synchronizer) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT cycles, ±1 cycle of edge-sampling uncertainty.
- `ready`, `rx_data` and `frame_err` change only on the stop-sample edge or on `clear`/`rst`.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset then idle: `txd`=1, `busy`=0, `ready`=0, `rx_data`=0, `frame_err`=0 for 100 cycles.
- Transmit: `start` pulse with `tx_data`=0xDEADBEA5 → `txd` outputs 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. `busy` is high for exactly 40 cycles. A second `start` at cycle 20 is ignored.
- Receive 0x3C as a valid frame → `ready`=1 and `rx_data`=0x0000003C. A `clear` pulse then gives `ready`=0 next cycle with `rx_data` held.
- Frame error: send 0x55 with a low stop bit → `frame_err`=1, `ready`/`rx_data` unchanged. A following good 0x12 gives `frame_err`=0, `ready`=1, `rx_data`=0x12.
- Races:
  - A 2-cycle low glitch on `rxd` produces no state change.
  - `clear` on the same cycle as a good stop sample of 0x81 leaves `ready`=1 and `rx_data`=0x81.
- Reset mid-transmit at bit 4 → `txd`=1 and `busy`=0 immediately. A fresh `start` with 0x00 then transmits a correct frame.
